iob_native_ram_arb: RTL and testbench
=====================================

Name: iob_native_ram_arb

Overview:
- Multi-port native-interface memory model for DMA and interconnect benches; the next generation of the team's single-port delayed RAM.
- Serves N_PORTS native masters through one shared word-addressed RAM.
- Arbitration is round-robin; each port has its own programmable wait states; writes honour per-byte strobes.
- Instantiated behind iob_dma ports A/B and in multi-master subsystem tests.

Parameters:
N_PORTS, 2, number of native slave ports (1..8)
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 24, byte-address width per port
MEM_ADDR_W, 10, log2 of RAM depth in words
DELAY_W, 3, width of per-port wait-state field

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
valid  in  N_PORTS  request valid, bit p = port p
addr  in  N_PORTS*ADDR_W  byte address; slice p = port p
wdata  in  N_PORTS*DATA_W  write data per port
wstrb  in  N_PORTS*DATA_W/8  byte enables per port; all-zero means read
rdata  out  N_PORTS*DATA_W  read data; every slice is driven from one shared register
ready  out  N_PORTS  one-cycle completion pulse per port
port_delay  in  N_PORTS*DELAY_W  wait states for port p; sampled at grant

Behaviour:
- Reset (rst=0, async):
  - State returns to IDLE immediately.
  - ready=0, rdata=0, counter=0, last_grant=N_PORTS-1.
  - RAM contents are not cleared.
- Word index = addr >> log2(DATA_W/8), truncated to MEM_ADDR_W bits. Higher bits are ignored, so addresses alias modulo the depth.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If any valid bit is set, grant the first requester searching from (last_grant+1) mod N_PORTS upward, with wrap.
  - Latch grant, addr, wdata and wstrb; counter <= port_delay[grant].
  - Next state is WAIT if the delay is nonzero, otherwise ACCESS.
  - If no valid bit is set, stay in IDLE.
- WAIT: counter decrements each cycle; go to ACCESS when counter==1.
- ACCESS (one cycle):
  - Write: each byte b with wstrb[b]=1 is written from the latched wdata; other bytes are kept.
  - Read: rdata <= mem[index]. rdata is unchanged on writes.
  - Next state is RESP.
- RESP (one cycle):
  - ready[grant]=1; all other ready bits are 0.
  - last_grant <= grant; next state is IDLE.
- ready is registered and is never high on more than one bit. rdata holds its value until the next read.
- Latency, from the first edge with valid high to the cycle ready is high: d+2 cycles for delay d.
  - Example, d=0: grant at edge E0, access at E1, ready high E1..E2.
- Requester protocol:
  - Hold valid/addr/wdata/wstrb until ready is seen.
  - Drop valid, or present a new request, before the edge following the ready cycle. The block spends that cycle in IDLE and samples valid at the end of it.
- Throughput: one transaction per d+3 cycles per grant.
- Requests are latched at grant, so later changes to addr/wdata/wstrb are ignored.
- If valid drops while a request is in WAIT or ACCESS, the access still completes (a write is committed) and the ready pulse is still issued.
- Fairness: with all ports continuously requesting, grants rotate 0,1,..,N-1,0.
- A port that is not requesting is skipped with no idle cycle.
- Reset asserted in WAIT/ACCESS/RESP:
  - The pending access is dropped if the ACCESS edge has not occurred.
  - No ready pulse is issued.
  - After release, arbitration starts at port 0.

Test Plan:
- Write: port0, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, delay 0 -> ready[0] high for exactly 1 cycle, 2 cycles after valid. A later read of 0x10 returns 0xDEADBEEF.
- Byte strobes: preload word 0x11223344, write wstrb 0x5, wdata 0xAABBCCDD -> readback 0x11BB33DD. A read with wstrb 0 leaves the word unchanged.
- Wait states: port1 delay 5, read -> ready[1] high 7 cycles after valid, single cycle, rdata correct. A delay of 0 on the next access gives 2 cycles.
- Contention:
  - N_PORTS=2, both ports valid from reset, continuous requests -> grant order 0,1,0,1.
  - N_PORTS=3, last grant 0, ports 0 and 2 requesting -> port2 served, then port0.
- Aliasing: MEM_ADDR_W=10, write byte address 0x1000 -> word 0 is modified. A read at 0x0 returns the written value.
- Reset mid-operation: port0 write, delay 4, rst low during WAIT -> ready stays 0 and the target word is unchanged. After release, simultaneous requests from ports 0 and 1 go to port0 first.

Source files
------------

// File: rtl/iob_native_ram_arb.sv
// Multi-port native-interface RAM model: round-robin arbitration over N_PORTS masters,
// per-port wait states and byte-strobed writes into one shared word-addressed array.
module iob_native_ram_arb #(
    parameter int N_PORTS    = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 24,
    parameter int MEM_ADDR_W = 10,
    parameter int DELAY_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          valid,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    input  logic [N_PORTS*DATA_W/8-1:0] wstrb,
    output logic [N_PORTS*DATA_W-1:0]   rdata,
    output logic [N_PORTS-1:0]          ready,
    input  logic [N_PORTS*DELAY_W-1:0]  port_delay
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_OFF = $clog2(STRB_W);
    localparam int PTR_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH    = 2 ** MEM_ADDR_W;
    localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1);
    localparam logic [PTR_W-1:0]   LAST_RST = PTR_W'(N_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_t state_r, state_nxt_s;

    logic [ADDR_W-1:0]     addr_arr_s  [N_PORTS];
    logic [DATA_W-1:0]     wdata_arr_s [N_PORTS];
    logic [STRB_W-1:0]     wstrb_arr_s [N_PORTS];
    logic [DELAY_W-1:0]    delay_arr_s [N_PORTS];

    logic                  found_s;
    logic [PTR_W-1:0]      pick_s;
    logic [PTR_W-1:0]      cand_s;
    logic [PTR_W-1:0]      last_grant_r;
    logic [PTR_W-1:0]      grant_r;
    logic [MEM_ADDR_W-1:0] idx_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [STRB_W-1:0]     wstrb_r;
    logic [DELAY_W-1:0]    counter_r;
    logic [N_PORTS-1:0]    ready_r;
    logic [DATA_W-1:0]     rdata_r;
    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic                  addr_unused_s;

    // Split the flat port buses into per-port views
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            addr_arr_s[p]  = addr[p*ADDR_W +: ADDR_W];
            wdata_arr_s[p] = wdata[p*DATA_W +: DATA_W];
            wstrb_arr_s[p] = wstrb[p*STRB_W +: STRB_W];
            delay_arr_s[p] = port_delay[p*DELAY_W +: DELAY_W];
        end
    end

    // Round-robin pick: first requester after the last served port, wrapping
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand_s = PTR_W'((int'(last_grant_r) + 1 + i) % N_PORTS);
            if (!found_s && valid[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                pick_s  = pick_s;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    if (delay_arr_s[pick_s] != '0) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = ACCESS;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (counter_r <= CNT_ONE) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch, wait counter, response pulse and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= LAST_RST;
            grant_r      <= '0;
            idx_r        <= '0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            counter_r    <= '0;
            ready_r      <= '0;
            rdata_r      <= '0;
        end else begin
            ready_r <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r   <= pick_s;
                        idx_r     <= addr_arr_s[pick_s][BYTE_OFF +: MEM_ADDR_W];
                        wdata_r   <= wdata_arr_s[pick_s];
                        wstrb_r   <= wstrb_arr_s[pick_s];
                        counter_r <= delay_arr_s[pick_s];
                    end
                end
                WAIT: counter_r <= counter_r - CNT_ONE;
                ACCESS: begin
                    ready_r[grant_r] <= 1'b1;
                    if (wstrb_r == '0) begin
                        rdata_r <= mem_r[idx_r];
                    end
                end
                RESP:    last_grant_r <= grant_r;
                default: ready_r <= '0;
            endcase
        end
    end

    // RAM array; contents survive reset, writes only happen in ACCESS
    always_ff @(posedge clk) begin
        if (state_r == ACCESS && wstrb_r != '0) begin
            mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, wstrb_r);
        end
    end

    // Address bits above the word index alias and are deliberately ignored
    assign addr_unused_s = ^addr;
    assign rdata = {N_PORTS{rdata_r}};
    assign ready = ready_r;

endmodule

// File: tb/tb_iob_native_ram_arb.sv
// Directed scoreboard bench for iob_native_ram_arb: a 2-port instance for the main
// functions and a 3-port instance for the wrap-around arbitration case.
module tb_iob_native_ram_arb;
    localparam int N   = 2;
    localparam int N3  = 3;
    localparam int DW  = 32;
    localparam int AW  = 24;
    localparam int MW  = 10;
    localparam int DLW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*DW/8-1:0] wstrb;
    logic [N*DW-1:0]   rdata;
    logic [N-1:0]      ready;
    logic [N*DLW-1:0]  port_delay;

    logic [N3-1:0]      valid3;
    logic [N3*AW-1:0]   addr3;
    logic [N3*DW-1:0]   wdata3;
    logic [N3*DW/8-1:0] wstrb3;
    logic [N3*DW-1:0]   rdata3;
    logic [N3-1:0]      ready3;
    logic [N3*DLW-1:0]  port_delay3;

    iob_native_ram_arb #(.N_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(MW), .DELAY_W(DLW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .port_delay(port_delay)
    );

    iob_native_ram_arb #(.N_PORTS(N3), .DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(MW), .DELAY_W(DLW)) dut3 (
        .clk(clk), .rst(rst), .valid(valid3), .addr(addr3), .wdata(wdata3), .wstrb(wstrb3),
        .rdata(rdata3), .ready(ready3), .port_delay(port_delay3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        int          lat;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [2:0]  sb3[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [23:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] dl);
        addr[p*AW +: AW]         = a;
        wdata[p*DW +: DW]        = d;
        wstrb[p*4 +: 4]          = s;
        port_delay[p*DLW +: DLW] = dl;
    endtask

    // One transaction on the 2-port instance; drop_early releases valid after grant
    task automatic txn(input string tag, input int p, input logic [23:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] dl, input logic [31:0] exp_rd,
                       input bit drop_early);
        exp_t         e;
        exp_t         got;
        int           cyc;
        bit           seen;
        logic [N-1:0] oh;
        set_port(p, a, d, s, dl);
        valid[p] = 1'b1;
        e.port = p;
        e.lat  = int'(dl) + 2;
        e.rd   = (s == 4'h0) ? exp_rd : last_rd;
        sb.push_back(e);
        if (s == 4'h0) last_rd = exp_rd;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (drop_early && cyc == 1) valid[p] = 1'b0;
            if (ready != '0) seen = 1'b1;
        end
        valid[p] = 1'b0;
        got = sb.pop_front();
        oh = '0;
        oh[got.port] = 1'b1;
        check({tag, " ready seen"}, 64'(seen), 64'd1);
        check({tag, " ready bit"}, 64'(ready), 64'(oh));
        check({tag, " latency"}, 64'(cyc), 64'(got.lat));
        check({tag, " rdata"}, 64'(rdata[got.port*DW +: DW]), 64'(got.rd));
        @(negedge clk);
        check({tag, " single pulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        exp_t         e;
        exp_t         got;
        int           cyc;
        int           bad;
        bit           seen;
        logic [N-1:0] oh;
        logic [2:0]   exp3;

        rst = 1'b0;
        valid = '0; addr = '0; wdata = '0; wstrb = '0; port_delay = '0;
        valid3 = '0; addr3 = '0; wdata3 = '0; wstrb3 = '0; port_delay3 = '0;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(ready), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        txn("wr 0x10",        0, 24'h000010, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0,        1'b0);
        txn("rd 0x10",        0, 24'h000010, 32'h0,        4'h0, 3'd0, 32'hDEADBEEF, 1'b0);
        txn("preload 0x20",   0, 24'h000020, 32'h11223344, 4'hF, 3'd0, 32'h0,        1'b0);
        txn("strobe wr 0x20", 1, 24'h000020, 32'hAABBCCDD, 4'h5, 3'd0, 32'h0,        1'b0);
        txn("strobe rd 0x20", 0, 24'h000020, 32'h0,        4'h0, 3'd0, 32'h11BB33DD, 1'b0);
        txn("reread 0x20",    0, 24'h000020, 32'h0,        4'h0, 3'd0, 32'h11BB33DD, 1'b0);
        txn("wait5 rd p1",    1, 24'h000010, 32'h0,        4'h0, 3'd5, 32'hDEADBEEF, 1'b0);
        txn("wait0 rd p1",    1, 24'h000020, 32'h0,        4'h0, 3'd0, 32'h11BB33DD, 1'b0);
        txn("alias wr 0x1000",0, 24'h001000, 32'hCAFEF00D, 4'hF, 3'd1, 32'h0,        1'b0);
        txn("alias rd 0x0",   1, 24'h000000, 32'h0,        4'h0, 3'd0, 32'hCAFEF00D, 1'b0);
        txn("early drop wr",  1, 24'h000040, 32'h01234567, 4'hF, 3'd3, 32'h0,        1'b1);
        txn("early drop rd",  0, 24'h000040, 32'h0,        4'h0, 3'd2, 32'h01234567, 1'b0);

        // Reset while a delayed write is still waiting
        set_port(0, 24'h000040, 32'hFFFFFFFF, 4'hF, 3'd4);
        valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset ready", 64'(ready), 64'd0);
        check("mid reset rdata", 64'(rdata), 64'd0);
        last_rd = 32'h0;
        @(negedge clk);
        valid[0] = 1'b0;
        rst = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready != '0) bad++;
        end
        check("no ready after reset", 64'(bad), 64'd0);

        // Both ports request continuously; port0 reads the word the dropped write targeted
        set_port(0, 24'h000040, 32'h0, 4'h0, 3'd0);
        set_port(1, 24'h000010, 32'h0, 4'h0, 3'd0);
        e.port = 0; e.lat = 2; e.rd = 32'h01234567; sb.push_back(e);
        e.port = 1; e.lat = 3; e.rd = 32'hDEADBEEF; sb.push_back(e);
        e.port = 0; e.lat = 3; e.rd = 32'h01234567; sb.push_back(e);
        e.port = 1; e.lat = 3; e.rd = 32'hDEADBEEF; sb.push_back(e);
        valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (ready != '0) seen = 1'b1;
            end
            got = sb.pop_front();
            oh = '0;
            oh[got.port] = 1'b1;
            check($sformatf("rr%0d seen", k), 64'(seen), 64'd1);
            check($sformatf("rr%0d grant", k), 64'(ready), 64'(oh));
            check($sformatf("rr%0d spacing", k), 64'(cyc), 64'(got.lat));
            check($sformatf("rr%0d rdata", k), 64'(rdata[got.port*DW +: DW]), 64'(got.rd));
        end
        valid = '0;
        @(negedge clk);

        // 3-port instance: serve port0 first so the last grant is 0
        addr3[0 +: AW] = 24'h000008;
        wdata3[0 +: DW] = 32'h00000005;
        wstrb3[0 +: 4] = 4'hF;
        valid3 = 3'b001;
        cyc = 0;
        while (ready3 == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("p3 first grant", 64'(ready3), 64'd1);
        valid3 = '0;
        @(negedge clk);
        check("p3 first pulse", 64'(ready3), 64'd0);

        wstrb3 = '0;
        addr3[2*AW +: AW] = 24'h000008;
        sb3.push_back(3'b100);
        sb3.push_back(3'b001);
        valid3 = 3'b101;
        for (int k = 0; k < 2; k++) begin
            cyc = 0;
            @(negedge clk);
            while (ready3 == '0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            exp3 = sb3.pop_front();
            check($sformatf("p3 order%0d", k), 64'(ready3), 64'(exp3));
            check($sformatf("p3 rdata%0d", k), 64'(rdata3[DW +: DW]), 64'h5);
            valid3 = valid3 & ~ready3;
        end
        valid3 = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
